// File: rtl/dl_reg_wr_arb.sv
// Round-robin write arbiter owning one shared register; NUM_REQ agents contend for it.
// Define DL_REG_WR_ARB_LOCK_EN to add the per-requester burst lock (lock port, LOCKED state).
module dl_reg_wr_arb #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BITS = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*NUM_BITS-1:0]  wdata,
`ifdef DL_REG_WR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           lock,
`endif
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_BITS-1:0]          q,
    output logic                         q_vld,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         locked
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    logic [NUM_BITS-1:0] q_q, q_d;
    logic                q_vld_q, q_vld_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    state_t              state_q, state_d;

    logic [IDX_W-1:0]    base;
    logic [IDX_W-1:0]    cand;
    logic                rr_hit;
    logic [IDX_W-1:0]    rr_idx;
    logic                gnt_hit;
    logic [IDX_W-1:0]    gnt_idx;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    always_comb begin
        base = ptr_q;
`ifdef DL_REG_WR_ARB_LOCK_EN
        // A releasing owner hands the search to its successor in the same cycle.
        if (state_q == ST_LOCKED) begin
            base = inc_idx(owner_q);
        end
`endif
        cand   = base;
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_hit && req[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
            cand = inc_idx(cand);
        end

        gnt_hit = rr_hit;
        gnt_idx = rr_idx;
`ifdef DL_REG_WR_ARB_LOCK_EN
        if (state_q == ST_LOCKED && req[owner_q]) begin
            gnt_hit = 1'b1;
            gnt_idx = owner_q;
        end
`endif
        if (!rst_n) begin
            gnt_hit = 1'b0;
        end
        gnt = gnt_hit ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        q_d     = q_q;
        q_vld_d = q_vld_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        state_d = state_q;
        if (gnt_hit) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_idx == IDX_W'(i)) begin
                    q_d = wdata[i*NUM_BITS +: NUM_BITS];
                end
            end
            q_vld_d = 1'b1;
            owner_d = gnt_idx;
            ptr_d   = inc_idx(gnt_idx);
        end
`ifdef DL_REG_WR_ARB_LOCK_EN
        if (gnt_hit && lock[gnt_idx]) begin
            state_d = ST_LOCKED;
            ptr_d   = ptr_q;
        end else begin
            state_d = ST_ARB;
            if (state_q == ST_LOCKED && !gnt_hit) begin
                ptr_d = inc_idx(owner_q);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            q_vld_q <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            state_q <= ST_ARB;
        end else begin
            q_q     <= q_d;
            q_vld_q <= q_vld_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            state_q <= state_d;
        end
    end

    assign q      = q_q;
    assign q_vld  = q_vld_q;
    assign owner  = owner_q;
    assign locked = (state_q == ST_LOCKED);

endmodule
